// File: rtl/spi_slave_if_if.sv
// Register-side access bus between the SPI front end and the register block.
interface spi_slave_if_if;
  logic       rw;
  logic       valid;
  logic [3:0] addr_to_reg;
  logic [7:0] data_to_reg;
  logic [7:0] data_in_reg;

  modport master (output rw, valid, addr_to_reg, data_to_reg, input data_in_reg);
  modport slave  (input rw, valid, addr_to_reg, data_to_reg, output data_in_reg);
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversamples SCLK/CS_N/MOSI in clk, decodes 16-bit frames
// into single-cycle register accesses and returns read data on MISO within the same frame.
module spi_slave_if #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           spi_sclk,
    input  logic           spi_cs_n,
    input  logic           spi_mosi,
    output logic           spi_miso,
    spi_slave_if_if.master reg_bus,
    output logic           frame_err,
    output logic           busy
);

    typedef enum logic [2:0] {IDLE, CMD, RD_WAIT, DATA, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_h, cs_h;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [4:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_nxt;
    logic [7:0] tx_sr, tx_nxt;
    logic [7:0] wait_cnt;

    logic latch_cmd, strobe_rd, strobe_wr, load_tx, shift_tx;
    logic rw_nxt, miso_nxt, err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_h    <= 1'b0;
            cs_h      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_h    <= sclk_sync[SYNC_STAGES-1];
            cs_h      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_h & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_h & ~cs_s;
    assign cs_fall   = ~cs_s & cs_h;
    assign cs_rise   = cs_s & ~cs_h;
    assign busy      = ~cs_s;

    // Only 8 bits of history are ever needed: rw/addr at bit 8, write data at bit 16.
    assign rx_nxt = {rx_sr, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_nxt = CMD;
                CMD:     if (sclk_rise && bit_cnt == 5'd7) state_nxt = rx_nxt[7] ? DATA : RD_WAIT;
                RD_WAIT: if (wait_cnt == 8'(RD_LAT)) state_nxt = DATA;
                DATA:    if (sclk_rise && bit_cnt == 5'd15) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        latch_cmd = (state == CMD) && sclk_rise && (bit_cnt == 5'd7);
        strobe_rd = latch_cmd && !rx_nxt[7];
        strobe_wr = (state == DATA) && sclk_rise && (bit_cnt == 5'd15) && reg_bus.rw;
        load_tx   = (state == RD_WAIT) && (wait_cnt == 8'(RD_LAT));
        shift_tx  = sclk_fall && (bit_cnt >= 5'd9) && (bit_cnt <= 5'd15);
        rw_nxt    = latch_cmd ? rx_nxt[7] : reg_bus.rw;
        if (cs_rise)       tx_nxt = '0;
        else if (load_tx)  tx_nxt = reg_bus.data_in_reg;
        else if (shift_tx) tx_nxt = {tx_sr[6:0], 1'b0};
        else               tx_nxt = tx_sr;
        miso_nxt  = ((state_nxt == DATA) || (state_nxt == DONE)) && !rw_nxt && tx_nxt[7];
        err_nxt   = cs_rise && (bit_cnt != 5'd0) && (bit_cnt < 5'd16);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt             <= '0;
            rx_sr               <= '0;
            tx_sr               <= '0;
            wait_cnt            <= '0;
            spi_miso            <= 1'b0;
            frame_err           <= 1'b0;
            reg_bus.rw          <= 1'b0;
            reg_bus.valid       <= 1'b0;
            reg_bus.addr_to_reg <= '0;
            reg_bus.data_to_reg <= '0;
        end else begin
            if (cs_fall) begin
                bit_cnt <= '0;
            end else if (sclk_rise && bit_cnt < 5'd16) begin
                bit_cnt <= bit_cnt + 5'd1;
                rx_sr   <= rx_nxt[6:0];
            end
            tx_sr         <= tx_nxt;
            wait_cnt      <= (state == RD_WAIT) ? wait_cnt + 8'd1 : '0;
            spi_miso      <= miso_nxt;
            frame_err     <= err_nxt;
            reg_bus.valid <= strobe_rd | strobe_wr;
            if (latch_cmd) begin
                reg_bus.rw          <= rx_nxt[7];
                reg_bus.addr_to_reg <= rx_nxt[3:0];
            end
            if (strobe_wr) reg_bus.data_to_reg <= rx_nxt;
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomized frame-level bench for spi_slave_if with a transaction-queue reference model.
module tb_spi_slave_if;

    logic clk = 1'b0;
    logic rst_n, spi_sclk, spi_cs_n, spi_mosi;
    logic spi_miso, frame_err, busy;

    spi_slave_if_if bus ();

    spi_slave_if #(.SYNC_STAGES(2), .RD_LAT(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .reg_bus  (bus),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } acc_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    acc_t       exp_q[$];
    int         err_q[$];
    logic [7:0] mem[16];
    logic [7:0] ref_mem[16];
    logic [7:0] last_wdata;
    logic [7:0] mb;

    always @(posedge clk) cyc <= cyc + 1;

    // Register block: one-cycle read latency, random data_in_reg when not answering a read.
    always @(posedge clk) begin
        if (bus.valid && bus.rw) mem[bus.addr_to_reg] <= bus.data_to_reg;
        bus.data_in_reg <= (bus.valid && !bus.rw) ? mem[bus.addr_to_reg] : 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic clk_wait(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected strobes appear 3 clk after the edge is driven: 2 sync flops plus the output register.
    always @(negedge clk) begin
        acc_t e;
        int   ec;
        if (rst_n) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("valid_missing_cyc", 32'(cyc), 32'(e.cyc));
            end
            while (err_q.size() != 0 && err_q[0] < cyc) begin
                ec = err_q.pop_front();
                chk("frame_err_missing_cyc", 32'(cyc), 32'(ec));
            end
            if (bus.valid) begin
                chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("valid_cyc", 32'(cyc), 32'(e.cyc));
                    chk("valid_rw", 32'(bus.rw), 32'(e.rw));
                    chk("valid_addr", 32'(bus.addr_to_reg), 32'(e.addr));
                    chk("valid_data", 32'(bus.data_to_reg), 32'(e.data));
                end
            end
            if (frame_err) begin
                chk("frame_err_expected", 32'(err_q.size() != 0), 32'd1);
                if (err_q.size() != 0) begin
                    ec = err_q.pop_front();
                    chk("frame_err_cyc", 32'(cyc), 32'(ec));
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rw"}, 32'(bus.rw), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_addr"}, 32'(bus.addr_to_reg), 32'd0);
        chk({tag, "_data"}, 32'(bus.data_to_reg), 32'd0);
        chk({tag, "_miso"}, 32'(spi_miso), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic frame(input logic [15:0] w, input int unsigned nbits, input int unsigned gap,
                         input int unsigned rst_at, output logic [7:0] mbyte);
        logic       rd;
        logic [7:0] rdat;
        logic       exp_m;
        acc_t       e;
        rd    = !w[15];
        rdat  = ref_mem[w[11:8]];
        mbyte = '0;
        spi_cs_n = 1'b0;
        clk_wait($urandom_range(6, 4));
        chk("busy_in_frame", 32'(busy), 32'd1);
        for (int unsigned k = 1; k <= nbits; k++) begin
            spi_mosi = (k <= 16) ? w[16-k] : 1'($urandom_range(1, 0));
            clk_wait($urandom_range(6, 4));
            exp_m = (rd && k >= 9) ? rdat[(k <= 16) ? 16 - k : 0] : 1'b0;
            chk("miso_bit", 32'(spi_miso), 32'(exp_m));
            if (k >= 9 && k <= 16) mbyte = {mbyte[6:0], spi_miso};
            spi_sclk = 1'b1;
            if (k == 8 && rd) begin
                e = '{rw: 1'b0, addr: w[11:8], data: last_wdata, cyc: cyc + 3};
                exp_q.push_back(e);
            end
            if (k == 16 && !rd) begin
                e = '{rw: 1'b1, addr: w[11:8], data: w[7:0], cyc: cyc + 3};
                exp_q.push_back(e);
                last_wdata        = w[7:0];
                ref_mem[w[11:8]]  = w[7:0];
            end
            if (k == rst_at) begin
                clk_wait(1);
                rst_n = 1'b0;
                #1;
                check_zero_outputs("async_reset");
                spi_sclk = 1'b0;
                spi_cs_n = 1'b1;
                spi_mosi = 1'b0;
                exp_q.delete();
                err_q.delete();
                last_wdata = '0;
                clk_wait(3);
                rst_n = 1'b1;
                clk_wait(gap);
                return;
            end
            clk_wait($urandom_range(6, 4));
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        clk_wait($urandom_range(6, 4));
        spi_cs_n = 1'b1;
        if (nbits >= 1 && nbits <= 15) err_q.push_back(cyc + 3);
        clk_wait(gap);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [15:0]  w;
        int unsigned  nb, sel;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[10] = 8'hA7; ref_mem[10] = 8'hA7;
        last_wdata = '0;
        rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        clk_wait(4);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        clk_wait(4);

        frame(16'h853C, 16, 6, 0, mb);
        chk("t1_rw", 32'(bus.rw), 32'd1);
        chk("t1_addr", 32'(bus.addr_to_reg), 32'h5);
        chk("t1_data", 32'(bus.data_to_reg), 32'h3C);

        frame(16'h0A00, 16, 6, 0, mb);
        chk("t2_miso_byte", 32'(mb), 32'hA7);
        chk("t2_rw", 32'(bus.rw), 32'd0);
        chk("t2_addr", 32'(bus.addr_to_reg), 32'hA);

        frame(16'h8FFF, 10, 6, 0, mb);
        chk("t3_data_kept", 32'(bus.data_to_reg), 32'h3C);

        frame(16'h8155, 20, 6, 0, mb);
        chk("t4_addr", 32'(bus.addr_to_reg), 32'h1);
        chk("t4_data", 32'(bus.data_to_reg), 32'h55);

        frame(16'h8211, 16, 4, 0, mb);
        frame(16'h8322, 16, 4, 0, mb);
        chk("t5_addr", 32'(bus.addr_to_reg), 32'h3);
        chk("t5_data", 32'(bus.data_to_reg), 32'h22);
        frame(16'hF4AB, 16, 6, 0, mb);
        chk("t5_reserved_addr", 32'(bus.addr_to_reg), 32'h4);
        chk("t5_reserved_data", 32'(bus.data_to_reg), 32'hAB);

        frame(16'h0300, 16, 6, 12, mb);
        frame(16'h8C5A, 16, 6, 0, mb);
        chk("t6_rw", 32'(bus.rw), 32'd1);
        chk("t6_addr", 32'(bus.addr_to_reg), 32'hC);
        chk("t6_data", 32'(bus.data_to_reg), 32'h5A);

        for (int i = 0; i < 40; i++) begin
            w   = 16'($urandom);
            sel = $urandom_range(99, 0);
            if (sel < 70)      nb = 16;
            else if (sel < 85) nb = $urandom_range(15, 1);
            else               nb = $urandom_range(20, 17);
            frame(w, nb, $urandom_range(8, 4), 0, mb);
        end

        clk_wait(10);
        chk("pending_valids", 32'(exp_q.size()), 32'd0);
        chk("pending_frame_errs", 32'(err_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
